down_timer: RTL and testbench

//   Loadable down-counting timer; the counting-down counterpart of the team's up counter.

---
 rtl/down_timer_pkg.sv | 17 +
 rtl/down_timer_if.sv | 42 ++++
 rtl/down_timer.sv | 135 +++++++++++++
 tb/tb_down_timer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
//   Shared types and defaults for the loadable down-counting timer.
//   - down_timer_state_t : IDLE / RUN / DONE state encoding
//   - DOWN_TIMER_WIDTH_DEFAULT : default counter width in bits
// -----------------------------------------------------------------------------
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } down_timer_state_t;

    localparam int DOWN_TIMER_WIDTH_DEFAULT = 4;

endpackage : down_timer_pkg

// File: rtl/down_timer_if.sv
// -----------------------------------------------------------------------------
// down_timer_if
//   Control/status bundle of the down timer.
//   master : drives start, load_value, enable, abort; observes count, busy, done
//   slave  : the timer itself (inverse directions)
//   Parameter WIDTH : width of load_value and count.
// -----------------------------------------------------------------------------
interface down_timer_if
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DOWN_TIMER_WIDTH_DEFAULT
);

    logic             start;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output load_value,
        output enable,
        output abort,
        input  count,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  load_value,
        input  enable,
        input  abort,
        output count,
        output busy,
        output done
    );

endinterface : down_timer_if

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable down-counting timer. An accepted start loads load_value and the
//   timer decrements once per enabled cycle; reaching zero gives one DONE
//   cycle with done=1. abort returns to IDLE with count=0.
//   Priority: reset > abort > start > enable.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset
//     bus    : down_timer_if.slave (start, load_value, enable, abort in;
//              count, busy, done out -- all outputs registered)
//
//   Optional feature: define DOWN_TIMER_AUTO_RELOAD_EN to make DONE reload
//   the last loaded value and keep running periodically. Without it DONE
//   returns to IDLE and no reload register exists.
// -----------------------------------------------------------------------------
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DOWN_TIMER_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    down_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    down_timer_state_t state_r;
    down_timer_state_t state_next_s;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0]  reload_r;
    logic [WIDTH-1:0]  reload_next_s;
`endif

    // State, count, reload value and decoded outputs register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_r <= ZERO;
`endif
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_r <= reload_next_s;
`endif
        end
    end

    // Next-state and next-count decision, abort > start > enable.
    always_comb begin
        state_next_s  = state_r;
        count_next_s  = count_r;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        reload_next_s = reload_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (bus.abort) begin
                    state_next_s = IDLE;
                    count_next_s = ZERO;
                end else if (bus.start) begin
                    // A zero load finishes immediately: straight to DONE.
                    count_next_s = bus.load_value;
                    state_next_s = (bus.load_value == ZERO) ? DONE : RUN;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    reload_next_s = bus.load_value;
`endif
                end else if (state_r == DONE) begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    // Periodic mode; a zero period keeps done asserted.
                    if (reload_r == ZERO) begin
                        state_next_s = DONE;
                        count_next_s = ZERO;
                    end else begin
                        state_next_s = RUN;
                        count_next_s = reload_r;
                    end
`else
                    state_next_s = IDLE;
                    count_next_s = ZERO;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next_s = IDLE;
                    count_next_s = ZERO;
                end else if (bus.enable) begin
                    // <= ONE also guards against ever wrapping below zero.
                    if (count_r <= ONE) begin
                        state_next_s = DONE;
                        count_next_s = ZERO;
                    end else begin
                        count_next_s = count_r - ONE;
                    end
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = ZERO;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_next_s = (state_next_s == RUN);
        done_next_s = (state_next_s == DONE);
    end

    assign bus.count = count_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Directed bench for down_timer (WIDTH=4). Each scenario task drives inputs
//   and compares {count, busy, done} against hand-computed values one cycle
//   at a time. The periodic scenario is compiled in when
//   DOWN_TIMER_AUTO_RELOAD_EN is defined.
// -----------------------------------------------------------------------------
module tb_down_timer;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    down_timer_if #(.WIDTH(4)) bus ();

    down_timer #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.abort  = 1'b1;
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        step();
        bus.abort  = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = {bus.count, bus.busy, bus.done};
            checks++;
            if (got !== 6'b0000_00) begin
                failures++;
                $display("FAIL reset cyc=%0d {count,busy,done} got=%h exp=%h", i, got, 6'h00);
            end
        end
        reset = 1'b0;
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== 6'b0000_00) begin
            failures++;
            $display("FAIL reset_release {count,busy,done} got=%h exp=%h", got, 6'h00);
        end
    endtask

    task automatic test_basic_count();
        logic [5:0] exp [5];
        logic [5:0] got;
        exp[0] = {4'd3, 2'b10};
        exp[1] = {4'd2, 2'b10};
        exp[2] = {4'd1, 2'b10};
        exp[3] = {4'd0, 2'b01};
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        exp[4] = {4'd3, 2'b10};
`else
        exp[4] = {4'd0, 2'b00};
`endif
        bus.load_value = 4'd3;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            got = {bus.count, bus.busy, bus.done};
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL basic_count cyc=%0d {count,busy,done} got=%h exp=%h", i, got, exp[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_enable_pause();
        logic [3:0] exp_cnt [9];
        logic [5:0] exp;
        logic [5:0] got;
        exp_cnt = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        bus.load_value = 4'd5;
        bus.start      = 1'b1;
        bus.enable     = 1'b0;
        step();
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd5, 2'b10}) begin
            failures++;
            $display("FAIL pause_load {count,busy,done} got=%h exp=%h", got, {4'd5, 2'b10});
        end
        for (int i = 0; i < 9; i++) begin
            bus.enable = (i % 2 == 0);
            // start during RUN must be ignored
            bus.start  = (i == 1);
            bus.load_value = 4'd12;
            step();
            exp = (i == 8) ? {exp_cnt[i], 2'b01} : {exp_cnt[i], 2'b10};
            got = {bus.count, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL enable_pause cyc=%0d {count,busy,done} got=%h exp=%h", i, got, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_zero_load();
        logic [5:0] got;
        logic [5:0] exp;
        bus.load_value = 4'd0;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        step();
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b01}) begin
            failures++;
            $display("FAIL zero_load {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b01});
        end
        step();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        exp = {4'd0, 2'b01};
`else
        exp = {4'd0, 2'b00};
`endif
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL zero_load_after {count,busy,done} got=%h exp=%h", got, exp);
        end
        go_idle();
    endtask

    task automatic test_done_restart();
        logic [5:0] got;
        bus.load_value = 4'd1;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b01}) begin
            failures++;
            $display("FAIL restart_done {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b01});
        end
        bus.load_value = 4'd3;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd3, 2'b10}) begin
            failures++;
            $display("FAIL restart_load {count,busy,done} got=%h exp=%h", got, {4'd3, 2'b10});
        end
        go_idle();
    endtask

    task automatic test_all_ones();
        logic [5:0] got;
        logic [5:0] exp;
        bus.load_value = 4'hF;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        step();
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'hF, 2'b10}) begin
            failures++;
            $display("FAIL all_ones_load {count,busy,done} got=%h exp=%h", got, {4'hF, 2'b10});
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            exp = (i == 15) ? {4'd0, 2'b01} : {4'(15 - i), 2'b10};
            got = {bus.count, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL all_ones cyc=%0d {count,busy,done} got=%h exp=%h", i, got, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_abort_reset();
        logic [5:0] got;
        // abort beats start and enable at count=6
        bus.load_value = 4'd9;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd6, 2'b10}) begin
            failures++;
            $display("FAIL abort_pre {count,busy,done} got=%h exp=%h", got, {4'd6, 2'b10});
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b00}) begin
            failures++;
            $display("FAIL abort {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b00});
        end
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b00}) begin
            failures++;
            $display("FAIL abort_after {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b00});
        end
        // reset mid-run at count=4
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd4, 2'b10}) begin
            failures++;
            $display("FAIL reset_pre {count,busy,done} got=%h exp=%h", got, {4'd4, 2'b10});
        end
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b00}) begin
            failures++;
            $display("FAIL reset_mid {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b00});
        end
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b00}) begin
            failures++;
            $display("FAIL reset_mid_after {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b00});
        end
        bus.enable = 1'b0;
    endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [5:0] exp [7];
        logic [5:0] got;
        exp = '{{4'd2, 2'b10}, {4'd1, 2'b10}, {4'd0, 2'b01},
                {4'd2, 2'b10}, {4'd1, 2'b10}, {4'd0, 2'b01},
                {4'd2, 2'b10}};
        bus.load_value = 4'd2;
        bus.start      = 1'b1;
        bus.enable     = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.start = 1'b0;
            got = {bus.count, bus.busy, bus.done};
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL auto_reload cyc=%0d {count,busy,done} got=%h exp=%h", i, got, exp[i]);
            end
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        got = {bus.count, bus.busy, bus.done};
        checks++;
        if (got !== {4'd0, 2'b00}) begin
            failures++;
            $display("FAIL auto_reload_abort {count,busy,done} got=%h exp=%h", got, {4'd0, 2'b00});
        end
        bus.enable = 1'b0;
    endtask
`endif

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.load_value = 4'd0;
        bus.enable     = 1'b0;
        bus.abort      = 1'b0;
        test_reset();
        test_basic_count();
        test_enable_pause();
        test_zero_load();
        test_done_restart();
        test_all_ones();
        test_abort_reset();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_timer
